// File: rtl/regfile_wport_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wport_arbiter
//   Shares the single register-file write port between pipeline writeback (WB),
//   buffered load returns (LD) and debug host writes (DBG).
//
//   Handshakes:
//     LD  : valid/ready. A transfer happens in a cycle where ld_valid=1 and
//           ld_ready=1. ld_ready depends only on FIFO occupancy (not on
//           ld_valid). While full, ld_valid is ignored and the source holds.
//     DBG : four-phase level handshake. Host raises dbg_req with stable
//           addr/data, waits for dbg_ack=1, drops dbg_req, then waits for
//           dbg_ack=0 before raising again.
//     WB  : never back-pressured, but the core must keep wb_we=0 in any cycle
//           where core_stall=1.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-low reset
//     wb_we/wb_addr/wb_data    writeback request (highest priority)
//     ld_valid/ld_ready/...    load-return push into the FIFO
//     dbg_req/dbg_ack/...      debug write handshake
//     rd_addr1/2, pend1/2      decoder source lookup against queued loads
//     core_stall               one-cycle starvation stall (registered)
//     rf_we/rf_addrw/rf_wdata  register-file write port (registered)
//     fifo_count               load FIFO occupancy
//     dbg_state                current debug FSM state (for observation)
// -----------------------------------------------------------------------------
module regfile_wport_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wb_we,
   input  logic [4:0]                  wb_addr,
   input  logic [31:0]                 wb_data,
   input  logic                        ld_valid,
   output logic                        ld_ready,
   input  logic [4:0]                  ld_addr,
   input  logic [31:0]                 ld_data,
   input  logic                        dbg_req,
   input  logic [4:0]                  dbg_addr,
   input  logic [31:0]                 dbg_wdata,
   output logic                        dbg_ack,
   input  logic [4:0]                  rd_addr1,
   input  logic [4:0]                  rd_addr2,
   output logic                        pend1,
   output logic                        pend2,
   output logic                        core_stall,
   output logic                        rf_we,
   output logic [4:0]                  rf_addrw,
   output logic [31:0]                 rf_wdata,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [1:0]                  dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_WAIT = 2'd1,
      D_ACK  = 2'd2
   } dbg_state_t;

   // r0, r1 and r31 are hard-wired in the register file.
   function automatic logic is_prot(input logic [4:0] a);
      return (a == 5'd0) || (a == 5'd1) || (a == 5'd31);
   endfunction

   logic [4:0]            q_addr [FIFO_DEPTH];
   logic [31:0]           q_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] q_live;
   logic [AW-1:0]         rd_ptr, wr_ptr;
   logic [CW-1:0]         count;

   dbg_state_t  d_state, d_state_nx;
   logic [4:0]  d_addr;
   logic [31:0] d_data;
   logic        rr_dbg;          // 1: DBG wins the next LD/DBG contention
   logic [SW-1:0] starve_cnt;

   logic fifo_ne, d_wait, push, starve_inc;
   logic grant_ld, grant_dbg;
   logic wb_write, ld_write, dbg_write;

   assign fifo_ne    = (count != '0);
   assign d_wait     = (d_state == D_WAIT);
   assign ld_ready   = (count != CW'(FIFO_DEPTH));
   assign push       = ld_valid && ld_ready;
   assign starve_inc = wb_we && (fifo_ne || d_wait);
   assign fifo_count = count;
   assign dbg_ack    = (d_state == D_ACK);
   assign dbg_state  = d_state;

   // Grant: WB first, then round-robin between LD and DBG when both wait.
   // A push into an empty FIFO is not visible to fifo_ne until next cycle.
   always_comb begin
      grant_ld  = 1'b0;
      grant_dbg = 1'b0;
      if (!wb_we) begin
         if (fifo_ne && d_wait) begin
            if (rr_dbg) grant_dbg = 1'b1;
            else        grant_ld  = 1'b1;
         end else if (fifo_ne) begin
            grant_ld = 1'b1;
         end else if (d_wait) begin
            grant_dbg = 1'b1;
         end
      end
   end

   // Killed or protected entries are still consumed, just without a write.
   assign wb_write  = wb_we && !is_prot(wb_addr);
   assign ld_write  = grant_ld && q_live[rd_ptr] && !is_prot(q_addr[rd_ptr]);
   assign dbg_write = grant_dbg && !is_prot(d_addr);

   // FIFO storage; needs no reset since only entries inside count are read.
   // WB to X kills matching entries, including the one pushed this cycle.
   always_ff @(posedge clk) begin
      if (wb_we) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (q_addr[i] == wb_addr) q_live[i] <= 1'b0;
         end
      end
      if (push) begin
         q_addr[wr_ptr] <= ld_addr;
         q_data[wr_ptr] <= ld_data;
         q_live[wr_ptr] <= !(wb_we && (ld_addr == wb_addr));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)     wr_ptr <= wr_ptr + 1'b1;
         if (grant_ld) rd_ptr <= rd_ptr + 1'b1;
         case ({push, grant_ld})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Pending lookup over live entries between rd_ptr and rd_ptr+count-1.
   always_comb begin
      logic [AW-1:0] idx;
      idx   = '0;
      pend1 = 1'b0;
      pend2 = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if ((CW'(i) < count) && q_live[idx]) begin
            if (q_addr[idx] == rd_addr1) pend1 = 1'b1;
            if (q_addr[idx] == rd_addr2) pend2 = 1'b1;
         end
      end
      if (is_prot(rd_addr1)) pend1 = 1'b0;
      if (is_prot(rd_addr2)) pend2 = 1'b0;
   end

   // Debug FSM
   always_comb begin
      d_state_nx = d_state;
      case (d_state)
         D_IDLE:  if (dbg_req)   d_state_nx = D_WAIT;
         D_WAIT:  if (grant_dbg) d_state_nx = D_ACK;
         D_ACK:   if (!dbg_req)  d_state_nx = D_IDLE;
         default: d_state_nx = D_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_state <= D_IDLE;
         d_addr  <= '0;
         d_data  <= '0;
      end else begin
         d_state <= d_state_nx;
         if ((d_state == D_IDLE) && dbg_req) begin
            d_addr <= dbg_addr;
            d_data <= dbg_wdata;
         end
      end
   end

   // Round-robin pointer and starvation guard
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_dbg     <= 1'b0;
         starve_cnt <= '0;
         core_stall <= 1'b0;
      end else begin
         if (grant_ld || grant_dbg) rr_dbg <= ~rr_dbg;
         core_stall <= 1'b0;
         if (starve_inc) begin
            if (starve_cnt == STARVE_LAST) begin
               starve_cnt <= '0;
               core_stall <= 1'b1;
            end else begin
               starve_cnt <= starve_cnt + 1'b1;
            end
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   // Write port register: one-cycle pulse, address/data zero when idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we    <= 1'b0;
         rf_addrw <= '0;
         rf_wdata <= '0;
      end else if (wb_write) begin
         rf_we    <= 1'b1;
         rf_addrw <= wb_addr;
         rf_wdata <= wb_data;
      end else if (ld_write) begin
         rf_we    <= 1'b1;
         rf_addrw <= q_addr[rd_ptr];
         rf_wdata <= q_data[rd_ptr];
      end else if (dbg_write) begin
         rf_we    <= 1'b1;
         rf_addrw <= d_addr;
         rf_wdata <= d_data;
      end else begin
         rf_we    <= 1'b0;
         rf_addrw <= '0;
         rf_wdata <= '0;
      end
   end

endmodule
